// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light configuration stage.
// Contents: edit FSM state encoding, BCD digit limits and a saturating step helper.
package traffic_pkg;

    localparam logic [1:0] RUN          = 2'd0;
    localparam logic [1:0] EDIT_COUNTRY = 2'd1;
    localparam logic [1:0] EDIT_YELLOW  = 2'd2;

    localparam logic [3:0] BCD_MIN = 4'd1;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Increment or decrement a single digit, clamped to [lo, hi].
    // When neither or both of inc/dec are set, the value is held.
    function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc,
                                            input logic dec, input logic [3:0] lo,
                                            input logic [3:0] hi);
        logic [3:0] r;
        r = v;
        if (inc && !dec) begin
            r = (v >= hi) ? hi : v + 4'd1;
        end else if (dec && !inc) begin
            r = (v <= lo) ? lo : v - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_timing_config_if.sv
// Front-panel / controller bundle of the timing configuration stage.
// Buttons: btn_mode_async, btn_up_async, btn_down_async (raw, active-high).
// Results: time_country, time_yellow (committed), editing, edit_field, edit_value,
//          config_update (one-cycle pulse after a commit).
// master: the panel/controller side; slave: the configuration stage.
interface traffic_timing_config_if;

    logic       btn_mode_async;
    logic       btn_up_async;
    logic       btn_down_async;
    logic [3:0] time_country;
    logic [3:0] time_yellow;
    logic       editing;
    logic       edit_field;
    logic [3:0] edit_value;
    logic       config_update;

    modport master (
        output btn_mode_async, btn_up_async, btn_down_async,
        input  time_country, time_yellow, editing, edit_field, edit_value, config_update
    );

    modport slave (
        input  btn_mode_async, btn_up_async, btn_down_async,
        output time_country, time_yellow, editing, edit_field, edit_value, config_update
    );

endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, debouncer and rising-edge detector.
// Ports: clock, reset (sync, active-high), btn_async (raw button),
//        press (one-cycle pulse per debounced rising edge, registered).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_async,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The cycle that would bring the count to DEBOUNCE_CYCLES flips stable instead.
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_async;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= sync2_q;  // only the accepted rising level makes a press
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/traffic_timing_config.sv
// Timing configuration stage for the traffic light controller.
// Debounces the mode/up/down buttons and runs the RUN -> EDIT_COUNTRY -> EDIT_YELLOW
// edit loop. Edits happen on shadow copies; the committed time_country/time_yellow
// only change on the final mode press (or reset), so the controller never sees
// half-edited values. An idle edit is abandoned after EDIT_TIMEOUT press-free cycles.
// Ports: clock, reset (sync, active-high), cfg (slave side of traffic_timing_config_if).
module traffic_timing_config
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDIT_TIMEOUT    = 1000,
    parameter logic [3:0]  COUNTRY_DEFAULT = 4'd5,
    parameter logic [3:0]  YELLOW_DEFAULT  = 4'd3,
    parameter logic [3:0]  MIN_VALUE       = BCD_MIN,
    parameter logic [3:0]  MAX_VALUE       = BCD_MAX
) (
    input logic                     clock,
    input logic                     reset,
    traffic_timing_config_if.slave  cfg
);

    localparam int unsigned IW = $clog2(EDIT_TIMEOUT + 1);
    localparam logic [IW-1:0] IdleLast = IW'(EDIT_TIMEOUT - 1);

    logic press_mode, press_up, press_down;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clock     (clock),
        .reset     (reset),
        .btn_async (cfg.btn_mode_async),
        .press     (press_mode)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock     (clock),
        .reset     (reset),
        .btn_async (cfg.btn_up_async),
        .press     (press_up)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock     (clock),
        .reset     (reset),
        .btn_async (cfg.btn_down_async),
        .press     (press_down)
    );

    logic [1:0]    state_q, state_d;
    logic [3:0]    shadow_country_q, shadow_country_d;
    logic [3:0]    shadow_yellow_q, shadow_yellow_d;
    logic [3:0]    time_country_q, time_country_d;
    logic [3:0]    time_yellow_q, time_yellow_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          update_q, update_d;
    logic          any_press;

    assign any_press = press_mode | press_up | press_down;

    always_comb begin
        state_d          = state_q;
        shadow_country_d = shadow_country_q;
        shadow_yellow_d  = shadow_yellow_q;
        time_country_d   = time_country_q;
        time_yellow_d    = time_yellow_q;
        update_d         = 1'b0;
        idle_d           = (state_q == RUN || any_press) ? '0 : idle_q + IW'(1);

        unique case (state_q)
            RUN: begin
                if (press_mode) begin
                    state_d          = EDIT_COUNTRY;
                    shadow_country_d = time_country_q;
                    shadow_yellow_d  = time_yellow_q;
                end
            end
            EDIT_COUNTRY, EDIT_YELLOW: begin
                // Mode outranks up/down; sat_step drops up+down together.
                if (press_mode) begin
                    if (state_q == EDIT_COUNTRY) begin
                        state_d = EDIT_YELLOW;
                    end else begin
                        state_d        = RUN;
                        time_country_d = shadow_country_q;
                        time_yellow_d  = shadow_yellow_q;
                        update_d       = 1'b1;
                    end
                end else if (!any_press && idle_q == IdleLast) begin
                    state_d = RUN;
                end else if (state_q == EDIT_COUNTRY) begin
                    shadow_country_d = sat_step(shadow_country_q, press_up, press_down,
                                                MIN_VALUE, MAX_VALUE);
                end else begin
                    shadow_yellow_d = sat_step(shadow_yellow_q, press_up, press_down,
                                               MIN_VALUE, MAX_VALUE);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= RUN;
            shadow_country_q <= COUNTRY_DEFAULT;
            shadow_yellow_q  <= YELLOW_DEFAULT;
            time_country_q   <= COUNTRY_DEFAULT;
            time_yellow_q    <= YELLOW_DEFAULT;
            idle_q           <= '0;
            update_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            shadow_country_q <= shadow_country_d;
            shadow_yellow_q  <= shadow_yellow_d;
            time_country_q   <= time_country_d;
            time_yellow_q    <= time_yellow_d;
            idle_q           <= idle_d;
            update_q         <= update_d;
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    always_comb begin
        cfg.time_country  = time_country_q;
        cfg.time_yellow   = time_yellow_q;
        cfg.editing       = (state_q != RUN);
        cfg.edit_field    = (state_q == EDIT_YELLOW);
        cfg.config_update = update_q;
        cfg.edit_value    = 4'd0;
        if (state_q == EDIT_COUNTRY) begin
            cfg.edit_value = shadow_country_q;
        end else if (state_q == EDIT_YELLOW) begin
            cfg.edit_value = shadow_yellow_q;
        end
    end

endmodule

// File: tb/tb_traffic_timing_config.sv
// Directed bench for traffic_timing_config with DEBOUNCE_CYCLES=4, EDIT_TIMEOUT=20.
module tb_traffic_timing_config;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 20;

    localparam logic [2:0] M = 3'b100;
    localparam logic [2:0] U = 3'b010;
    localparam logic [2:0] D = 3'b001;

    typedef struct packed {
        logic [2:0] btns;
        logic       ed;
        logic       fld;
        logic [3:0] val;
        logic [3:0] tc;
        logic [3:0] ty;
        logic       upd;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   upd_cnt = 0;
    vec_t vecs[23];

    traffic_timing_config_if cfg_if ();

    traffic_timing_config #(
        .DEBOUNCE_CYCLES (DB),
        .EDIT_TIMEOUT    (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .cfg   (cfg_if)
    );

    always #5 clock = ~clock;

    // Counts high cycles of config_update; each commit must add exactly one.
    always @(negedge clock) begin
        if (cfg_if.config_update === 1'b1) upd_cnt++;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [2:0] b);
        cfg_if.btn_mode_async = b[2];
        cfg_if.btn_up_async   = b[1];
        cfg_if.btn_down_async = b[0];
    endtask

    // Raise buttons just after an edge; the FSM reacts at edge DB+3.
    task automatic press_hold(input logic [2:0] b);
        set_btns(b);
        repeat (DB + 3) @(posedge clock);
        #1;
    endtask

    // Drop all buttons and wait until the release is debounced.
    task automatic release_all();
        set_btns(3'b000);
        repeat (DB + 2) @(posedge clock);
        #1;
    endtask

    initial begin
        //              btns    ed    fld   val    tc     ty     upd
        vecs[0]  = '{U,     1'b1, 1'b0, 4'd6, 4'd5, 4'd3, 1'b0};
        vecs[1]  = '{U,     1'b1, 1'b0, 4'd7, 4'd5, 4'd3, 1'b0};
        vecs[2]  = '{U,     1'b1, 1'b0, 4'd8, 4'd5, 4'd3, 1'b0};
        vecs[3]  = '{M,     1'b1, 1'b1, 4'd3, 4'd5, 4'd3, 1'b0};
        vecs[4]  = '{D,     1'b1, 1'b1, 4'd2, 4'd5, 4'd3, 1'b0};
        vecs[5]  = '{D,     1'b1, 1'b1, 4'd1, 4'd5, 4'd3, 1'b0};
        vecs[6]  = '{D,     1'b1, 1'b1, 4'd1, 4'd5, 4'd3, 1'b0};
        vecs[7]  = '{D,     1'b1, 1'b1, 4'd1, 4'd5, 4'd3, 1'b0};
        vecs[8]  = '{D,     1'b1, 1'b1, 4'd1, 4'd5, 4'd3, 1'b0};
        vecs[9]  = '{M,     1'b0, 1'b0, 4'd0, 4'd8, 4'd1, 1'b1};
        vecs[10] = '{U,     1'b0, 1'b0, 4'd0, 4'd8, 4'd1, 1'b0};
        vecs[11] = '{M,     1'b1, 1'b0, 4'd8, 4'd8, 4'd1, 1'b0};
        vecs[12] = '{U,     1'b1, 1'b0, 4'd9, 4'd8, 4'd1, 1'b0};
        vecs[13] = '{U,     1'b1, 1'b0, 4'd9, 4'd8, 4'd1, 1'b0};
        vecs[14] = '{U | D, 1'b1, 1'b0, 4'd9, 4'd8, 4'd1, 1'b0};
        vecs[15] = '{M | U, 1'b1, 1'b1, 4'd1, 4'd8, 4'd1, 1'b0};
        vecs[16] = '{M,     1'b0, 1'b0, 4'd0, 4'd9, 4'd1, 1'b1};
        vecs[17] = '{M,     1'b1, 1'b0, 4'd9, 4'd9, 4'd1, 1'b0};
        vecs[18] = '{D,     1'b1, 1'b0, 4'd8, 4'd9, 4'd1, 1'b0};
        vecs[19] = '{M,     1'b1, 1'b1, 4'd1, 4'd9, 4'd1, 1'b0};
        vecs[20] = '{M,     1'b0, 1'b0, 4'd0, 4'd8, 4'd1, 1'b1};
        vecs[21] = '{M,     1'b1, 1'b0, 4'd8, 4'd8, 4'd1, 1'b0};
        vecs[22] = '{M,     1'b1, 1'b1, 4'd1, 4'd8, 4'd1, 1'b0};

        set_btns(3'b000);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset time_country", cfg_if.time_country, 4'd5);
        check("reset time_yellow", cfg_if.time_yellow, 4'd3);
        check("reset editing", 4'(cfg_if.editing), 4'd0);
        check("reset edit_value", cfg_if.edit_value, 4'd0);
        check("reset config_update", 4'(cfg_if.config_update), 4'd0);
        reset = 1'b0;

        // 3-cycle glitch on mode must be ignored.
        set_btns(M);
        repeat (3) @(posedge clock);
        #1;
        set_btns(3'b000);
        repeat (10) @(posedge clock);
        #1;
        check("glitch editing", 4'(cfg_if.editing), 4'd0);

        // Mode held 10 cycles: edit entered exactly after edge 7.
        set_btns(M);
        repeat (6) @(posedge clock);
        #1;
        check("hold edge6 editing", 4'(cfg_if.editing), 4'd0);
        @(posedge clock);
        #1;
        check("hold edge7 editing", 4'(cfg_if.editing), 4'd1);
        check("hold edge7 edit_field", 4'(cfg_if.edit_field), 4'd0);
        check("hold edge7 edit_value", cfg_if.edit_value, 4'd5);
        repeat (3) @(posedge clock);
        #1;
        release_all();

        for (int i = 0; i < 23; i++) begin
            press_hold(vecs[i].btns);
            check($sformatf("v%0d editing", i), 4'(cfg_if.editing), 4'(vecs[i].ed));
            check($sformatf("v%0d edit_field", i), 4'(cfg_if.edit_field), 4'(vecs[i].fld));
            check($sformatf("v%0d edit_value", i), cfg_if.edit_value, vecs[i].val);
            check($sformatf("v%0d time_country", i), cfg_if.time_country, vecs[i].tc);
            check($sformatf("v%0d time_yellow", i), cfg_if.time_yellow, vecs[i].ty);
            check($sformatf("v%0d config_update", i), 4'(cfg_if.config_update),
                  4'(vecs[i].upd));
            release_all();
        end
        check("update pulse count", 4'(upd_cnt), 4'd3);

        // Reset in EDIT_YELLOW with mode held across it.
        set_btns(M);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset time_country", cfg_if.time_country, 4'd5);
        check("midreset time_yellow", cfg_if.time_yellow, 4'd3);
        check("midreset editing", 4'(cfg_if.editing), 4'd0);
        check("midreset edit_field", 4'(cfg_if.edit_field), 4'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (DB + 2) @(posedge clock);
        #1;
        check("held early editing", 4'(cfg_if.editing), 4'd0);
        @(posedge clock);
        #1;
        check("held entry editing", 4'(cfg_if.editing), 4'd1);
        check("held entry edit_value", cfg_if.edit_value, 4'd5);
        release_all();

        // Timeout: up twice, then idle until 20 press-free cycles have elapsed.
        press_hold(U);
        check("timeout up1 value", cfg_if.edit_value, 4'd6);
        release_all();
        press_hold(U);
        check("timeout up2 value", cfg_if.edit_value, 4'd7);
        release_all();
        repeat (TO - (DB + 2) - 1) @(posedge clock);
        #1;
        check("timeout idle19 editing", 4'(cfg_if.editing), 4'd1);
        @(posedge clock);
        #1;
        check("timeout idle20 editing", 4'(cfg_if.editing), 4'd0);
        check("timeout time_country", cfg_if.time_country, 4'd5);
        check("timeout time_yellow", cfg_if.time_yellow, 4'd3);
        check("timeout update count", 4'(upd_cnt), 4'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_timing_config.md
# traffic_timing_config

Upstream configuration stage for the traffic light controller. It takes three raw front-panel push-buttons (mode, up, down), synchronises and debounces them, and runs a small edit state machine. The state machine lets an operator change the country-road green time and the yellow time. It drives the committed 4-bit `time_country` and `time_yellow` values straight into the controller's `time_country` / `time_yellow` inputs, so the controller never sees half-edited values.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a button level change (≥2).
- `EDIT_TIMEOUT`, default 1000: idle cycles in an edit state before the edit is abandoned (≥2).
- `COUNTRY_DEFAULT`, default 4'd5: reset value of `time_country`.
- `YELLOW_DEFAULT`, default 4'd3: reset value of `time_yellow`.
- `MIN_VALUE` / `MAX_VALUE`, default 4'd1 / 4'd9: saturation limits; values are always single BCD digits.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_mode_async` in 1: raw mode button, asynchronous, active-high.
- `btn_up_async` in 1: raw increment button.
- `btn_down_async` in 1: raw decrement button.
- `time_country` out 4: committed country green time, to the controller.
- `time_yellow` out 4: committed yellow time, to the controller.
- `editing` out 1: high while in either edit state.
- `edit_field` out 1: 0 = country, 1 = yellow. Valid only while `editing`; 0 otherwise.
- `edit_value` out 4: shadow value of the field being edited; 4'd0 in RUN.
- `config_update` out 1: one-cycle pulse on the cycle after a commit.

## Operation
- Per button: 2-flop synchroniser, then a debouncer, then a rising-edge detector that produces a one-cycle `press` pulse.
  - Debouncer keeps `stable` plus a counter.
  - Counter increments each cycle the synchronised input differs from `stable`, and clears to 0 on any cycle it matches.
  - When the counter reaches `DEBOUNCE_CYCLES`, `stable` takes the new level and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- FSM states: RUN, EDIT_COUNTRY, EDIT_YELLOW.
  - RUN: on mode press, go to EDIT_COUNTRY and load both shadow registers from the committed values. Up/down presses are ignored.
  - EDIT_COUNTRY: up press increments shadow_country, saturating at `MAX_VALUE`. Down press decrements it, saturating at `MIN_VALUE`. Mode press goes to EDIT_YELLOW.
  - EDIT_YELLOW: same up/down rules on shadow_yellow. Mode press goes to RUN, copies both shadows into the committed registers, and sets `config_update` for the next cycle.
- Simultaneous presses:
  - Mode with up or down in the same cycle: mode wins and the other press is dropped.
  - Up and down together: both dropped.
- Timeout: the idle counter clears on edit entry and on every press pulse. After `EDIT_TIMEOUT` consecutive press-free cycles in an edit state, return to RUN. No commit, no `config_update`, and the shadow values are discarded.
- Committed outputs change only at a commit or at reset. The controller keeps running on the old values throughout editing.
- Reset values:
  - FSM state: RUN.
  - Outputs: `time_country` = `COUNTRY_DEFAULT`, `time_yellow` = `YELLOW_DEFAULT`, `editing` = 0, `edit_field` = 0, `edit_value` = 0, `config_update` = 0.
  - Internal: synchronisers, `stable`, counters and the idle counter all 0.
- A button held high through reset is seen as a new press after reset deasserts.
- Reset mid-edit drops the edit and restores the defaults, not the last committed values.

## Timing
- Raw input goes high before edge 1 and is held: synchronised level high after edge 2, `stable` rises at edge 2+`DEBOUNCE_CYCLES`, `press` is high for the following cycle, and the FSM/shadow update is visible after edge 3+`DEBOUNCE_CYCLES`.
- The press pulse lasts exactly one cycle per debounced rising edge; holding a button gives no auto-repeat.
- The release is also debounced. A new press needs ≥`DEBOUNCE_CYCLES` low cycles first.
- Commit: `time_*` and the RUN state are visible after the same edge. `config_update` is high for the one cycle after that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `traffic_pkg`: state encoding localparams (RUN = 2'd0, EDIT_COUNTRY = 2'd1, EDIT_YELLOW = 2'd2) and the BCD limit constants.
- Sub-module `button_debouncer` (synchroniser + debouncer + edge detector, parameter `DEBOUNCE_CYCLES`), instantiated three times.
- Top level holds the FSM, shadow registers, committed registers and idle counter.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `EDIT_TIMEOUT`=20.
- **Reset:** `reset` held 2 cycles → `time_country`=5, `time_yellow`=3, `editing`=0, `edit_value`=0, `config_update`=0.
- **Glitch rejection:** mode high for 3 cycles, then low → state stays RUN. Mode held 10 cycles → `editing`=1 after edge 7, `edit_field`=0, `edit_value`=5.
- **Full edit:** mode, up×3, mode, down×5, mode → `time_country`=8, `time_yellow`=1, one `config_update` pulse. `time_*` are unchanged until the final mode press.
- **Saturation and simultaneous presses:** in EDIT_COUNTRY with shadow 9, press up → 9. Up and down pressed in the same cycle → no change. Mode and up in the same cycle → EDIT_YELLOW, shadow_country still 9.
- **Timeout:** enter edit, up×2, then 20 idle cycles → RUN, `time_country` still 5, no `config_update`.
- **Mid-edit reset and held button:** reset during EDIT_YELLOW with committed 8/1 → outputs 5/3, RUN. Mode held high across reset → enters EDIT_COUNTRY `DEBOUNCE_CYCLES`+3 edges after reset deasserts.
